// File: rtl/beep_pkg.sv
// Shared constants and types for the beep tone generator/decoder pair.
package beep_pkg;

  localparam int unsigned PERIOD_W  = 20;
  localparam int unsigned NUM_NOTES = 8;

  typedef enum logic [2:0] {
    NOTE_C5 = 3'd0,
    NOTE_E5 = 3'd1,
    NOTE_G5 = 3'd2,
    NOTE_C6 = 3'd3,
    NOTE_G4 = 3'd4,
    NOTE_E4 = 3'd5,
    NOTE_C4 = 3'd6,
    NOTE_A3 = 3'd7
  } note_e;

  // Nominal square-wave periods in 100 MHz cycles, indexed by note_e.
  localparam logic [PERIOD_W-1:0] NOM_PERIOD [NUM_NOTES] = '{
    20'd190836, 20'd151746, 20'd127552, 20'd95421,
    20'd255103, 20'd303031, 20'd381680, 20'd454546
  };

  localparam note_e UP_SEQ   [4] = '{NOTE_C5, NOTE_E5, NOTE_G5, NOTE_C6};
  localparam note_e DOWN_SEQ [4] = '{NOTE_G4, NOTE_E4, NOTE_C4, NOTE_A3};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEQ,
    ST_WAIT_QUIET
  } seq_state_e;

  function automatic logic [PERIOD_W-1:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                   input logic [PERIOD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/beep_period_meter.sv
// Synchronises the beep line, detects rising edges and measures edge-to-edge
// period with a silence timeout.
module beep_period_meter
  import beep_pkg::*;
#(
  parameter int unsigned SILENCE_CYCLES = 600000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                beep_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_stb,
  output logic                silence_stb
);

  localparam logic [PERIOD_W-1:0] SIL_CNT = PERIOD_W'(SILENCE_CYCLES);

  logic [2:0]          sync_q, sync_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                armed_q, armed_d;
  logic                silent_q, silent_d;
  logic                period_stb_q, period_stb_d;
  logic                silence_stb_q, silence_stb_d;
  logic                rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    sync_d        = {sync_q[1:0], beep_in};
    cnt_d         = cnt_q;
    period_d      = period_q;
    armed_d       = armed_q;
    silent_d      = silent_q;
    period_stb_d  = 1'b0;
    silence_stb_d = 1'b0;
    if (rise) begin
      cnt_d    = PERIOD_W'(1);
      armed_d  = 1'b1;
      silent_d = 1'b0;
      if (armed_q) begin
        period_d     = cnt_q;
        period_stb_d = 1'b1;
      end
    end else begin
      if (cnt_q != '1) cnt_d = cnt_q + PERIOD_W'(1);
      // silent_q makes the strobe fire once per quiet interval, even when saturated
      if (!silent_q && cnt_q >= SIL_CNT) begin
        silent_d      = 1'b1;
        armed_d       = 1'b0;
        silence_stb_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      cnt_q         <= '0;
      period_q      <= '0;
      armed_q       <= 1'b0;
      silent_q      <= 1'b1;
      period_stb_q  <= 1'b0;
      silence_stb_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      armed_q       <= armed_d;
      silent_q      <= silent_d;
      period_stb_q  <= period_stb_d;
      silence_stb_q <= silence_stb_d;
    end
  end

  assign period_out  = period_q;
  assign period_stb  = period_stb_q;
  assign silence_stb = silence_stb_q;

endmodule

// File: rtl/beep_tone_decoder.sv
// Classifies measured beep periods into game notes and recognises the
// four-note up/down sound effects.
module beep_tone_decoder
  import beep_pkg::*;
#(
  parameter int unsigned PERIOD_TOL     = 2048,
  parameter int unsigned MIN_PERIODS    = 3,
  parameter int unsigned SILENCE_CYCLES = 600000,
  parameter int unsigned NOM_SHIFT      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                beep_in,
  output logic [2:0]          note_code,
  output logic                note_valid,
  output logic [PERIOD_W-1:0] period_out,
  output logic                up_evt,
  output logic                down_evt,
  output logic                seq_err
);

  localparam logic [PERIOD_W-1:0] TOL_W = PERIOD_W'(PERIOD_TOL);
  localparam logic [2:0]          MIN_W = 3'(MIN_PERIODS);

  logic period_stb, silence_stb;

  beep_period_meter #(
    .SILENCE_CYCLES(SILENCE_CYCLES)
  ) u_meter (
    .clk        (clk),
    .rst        (rst),
    .beep_in    (beep_in),
    .period_out (period_out),
    .period_stb (period_stb),
    .silence_stb(silence_stb)
  );

  logic  match;
  note_e match_note;

  always_comb begin
    match      = 1'b0;
    match_note = NOTE_C5;
    for (int unsigned k = 0; k < NUM_NOTES; k++) begin
      if (abs_diff(period_out, NOM_PERIOD[k] >> NOM_SHIFT) <= TOL_W) begin
        match      = 1'b1;
        match_note = note_e'(3'(k));
      end
    end
  end

  note_e      last_note_q, last_note_d;
  note_e      note_code_q, note_code_d;
  logic [2:0] match_cnt_q, match_cnt_d;
  logic       note_valid_q, note_valid_d;
  logic       confirm_q, confirm_d;
  logic       same_run;

  always_comb begin
    last_note_d  = last_note_q;
    note_code_d  = note_code_q;
    match_cnt_d  = match_cnt_q;
    note_valid_d = note_valid_q;
    confirm_d    = 1'b0;
    same_run     = (match_cnt_q != 3'd0) && (match_note == last_note_q);
    if (silence_stb) begin
      match_cnt_d  = '0;
      note_valid_d = 1'b0;
    end else if (period_stb) begin
      if (!match) begin
        match_cnt_d  = '0;
        note_valid_d = 1'b0;
      end else begin
        if (same_run) begin
          if (match_cnt_q != 3'd7) match_cnt_d = match_cnt_q + 3'd1;
        end else begin
          match_cnt_d = 3'd1;
          last_note_d = match_note;
        end
        // a saturated run at MIN_PERIODS=7 must not re-confirm
        if (match_cnt_d == MIN_W && !(same_run && match_cnt_q == MIN_W)) begin
          confirm_d    = 1'b1;
          note_code_d  = match_note;
          note_valid_d = 1'b1;
        end
      end
    end
  end

  seq_state_e state_q, state_d;
  logic       dir_q, dir_d;
  logic [1:0] idx_q, idx_d;
  logic       up_evt_q, up_evt_d;
  logic       down_evt_q, down_evt_d;
  logic       seq_err_q, seq_err_d;
  logic [1:0] nxt_idx;
  note_e      exp_note;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    idx_d      = idx_q;
    up_evt_d   = 1'b0;
    down_evt_d = 1'b0;
    seq_err_d  = 1'b0;
    nxt_idx    = idx_q + 2'd1;
    exp_note   = dir_q ? DOWN_SEQ[nxt_idx] : UP_SEQ[nxt_idx];
    unique case (state_q)
      ST_IDLE: begin
        if (confirm_q && note_code_q == UP_SEQ[0]) begin
          state_d = ST_SEQ;
          dir_d   = 1'b0;
          idx_d   = 2'd0;
        end else if (confirm_q && note_code_q == DOWN_SEQ[0]) begin
          state_d = ST_SEQ;
          dir_d   = 1'b1;
          idx_d   = 2'd0;
        end
      end
      ST_SEQ: begin
        if (silence_stb) begin
          seq_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (confirm_q) begin
          if (note_code_q == exp_note) begin
            idx_d = nxt_idx;
            if (nxt_idx == 2'd3) begin
              up_evt_d   = ~dir_q;
              down_evt_d = dir_q;
              state_d    = ST_WAIT_QUIET;
            end
          end else begin
            seq_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_WAIT_QUIET: begin
        if (silence_stb) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_note_q  <= NOTE_C5;
      note_code_q  <= NOTE_C5;
      match_cnt_q  <= '0;
      note_valid_q <= 1'b0;
      confirm_q    <= 1'b0;
      state_q      <= ST_IDLE;
      dir_q        <= 1'b0;
      idx_q        <= '0;
      up_evt_q     <= 1'b0;
      down_evt_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      last_note_q  <= last_note_d;
      note_code_q  <= note_code_d;
      match_cnt_q  <= match_cnt_d;
      note_valid_q <= note_valid_d;
      confirm_q    <= confirm_d;
      state_q      <= state_d;
      dir_q        <= dir_d;
      idx_q        <= idx_d;
      up_evt_q     <= up_evt_d;
      down_evt_q   <= down_evt_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign note_code  = note_code_q;
  assign note_valid = note_valid_q;
  assign up_evt     = up_evt_q;
  assign down_evt   = down_evt_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_beep_tone_decoder.sv
// Randomised and directed bench for beep_tone_decoder using scaled-down
// note periods and a transaction-level reference model.
module tb_beep_tone_decoder;

  localparam int SHIFT = 11;
  localparam int TOL   = 3;
  localparam int MIN   = 3;
  localparam int SIL   = 600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        beep_in = 1'b0;
  logic [2:0]  note_code;
  logic        note_valid;
  logic [19:0] period_out;
  logic        up_evt, down_evt, seq_err;

  beep_tone_decoder #(
    .PERIOD_TOL    (TOL),
    .MIN_PERIODS   (MIN),
    .SILENCE_CYCLES(SIL),
    .NOM_SHIFT     (SHIFT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .beep_in   (beep_in),
    .note_code (note_code),
    .note_valid(note_valid),
    .period_out(period_out),
    .up_evt    (up_evt),
    .down_evt  (down_evt),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // observed pulse counts
  int up_cnt = 0, down_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    if (up_evt === 1'b1)   up_cnt++;
    if (down_evt === 1'b1) down_cnt++;
    if (seq_err === 1'b1)  err_cnt++;
  end

  // reference model
  int unsigned spec_nom [8] = '{190836, 151746, 127552, 95421, 255103, 303031, 381680, 454546};
  int nom [8];
  int up_seq [4]   = '{0, 1, 2, 3};
  int down_seq [4] = '{4, 5, 6, 7};
  int m_period, m_code, m_valid, m_note, m_run;
  int m_state, m_dir, m_pos;   // m_state: 0 idle, 1 in sequence, 2 waiting for quiet
  int exp_up = 0, exp_down = 0, exp_err = 0;
  int plan[$];

  function automatic int classify(input int p);
    for (int k = 0; k < 8; k++) begin
      int d = p - nom[k];
      if (d < 0) d = -d;
      if (d <= TOL) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_period = 0; m_code = 0; m_valid = 0; m_note = 0; m_run = 0;
    m_state = 0; m_dir = 0; m_pos = 0;
  endtask

  task automatic model_confirm(input int k);
    m_code  = k;
    m_valid = 1;
    if (m_state == 0) begin
      if (k == 0)      begin m_state = 1; m_dir = 0; m_pos = 1; end
      else if (k == 4) begin m_state = 1; m_dir = 1; m_pos = 1; end
    end else if (m_state == 1) begin
      if (k == (m_dir ? down_seq[m_pos] : up_seq[m_pos])) begin
        m_pos++;
        if (m_pos == 4) begin
          if (m_dir) exp_down++; else exp_up++;
          m_state = 2;
        end
      end else begin
        exp_err++;
        m_state = 0;
      end
    end
  endtask

  task automatic model_period(input int p);
    int k, prev;
    m_period = p;
    k = classify(p);
    if (k < 0) begin
      m_run = 0; m_valid = 0;
    end else begin
      prev  = (m_run > 0 && k == m_note) ? m_run : 0;
      m_note = k;
      m_run  = (prev == 0) ? 1 : ((prev < 7) ? prev + 1 : 7);
      if (m_run == MIN && prev != MIN) model_confirm(k);
    end
  endtask

  task automatic model_silence();
    m_valid = 0; m_run = 0;
    if (m_state == 1) exp_err++;
    m_state = 0;
  endtask

  task automatic check_state(input string tag);
    check_value({tag, "_period"}, period_out, m_period);
    check_value({tag, "_code"}, note_code, m_code);
    check_value({tag, "_valid"}, note_valid, m_valid);
    check_value({tag, "_up"}, up_cnt, exp_up);
    check_value({tag, "_down"}, down_cnt, exp_down);
    check_value({tag, "_err"}, err_cnt, exp_err);
  endtask

  task automatic add_note(input int k, input int reps, input bit jitter);
    for (int r = 0; r < reps; r++) begin
      int p = nom[k];
      if (jitter) begin
        case ($urandom_range(0, 3))
          0: p = nom[k] + TOL;
          1: p = nom[k] - TOL;
          default: p = nom[k] + $urandom_range(0, 2 * TOL) - TOL;
        endcase
      end
      plan.push_back(p);
    end
  endtask

  // Drives plan as rising edges spaced by each entry; optionally ends with silence.
  task automatic run_plan(input bit with_silence);
    for (int i = 0; i < plan.size(); i++) begin
      if (i > 0) model_period(plan[i-1]);
      beep_in = 1'b1;
      for (int c = 1; c <= plan[i]; c++) begin
        @(posedge clk); #1;
        if (c == plan[i] / 2) beep_in = 1'b0;
        if (c == 8 && i > 0) check_state("edge");
      end
    end
    if (with_silence) begin
      model_period(plan[plan.size()-1]);
      beep_in = 1'b1;
      for (int c = 1; c <= SIL + 30; c++) begin
        @(posedge clk); #1;
        if (c == 20) beep_in = 1'b0;
        if (c == 8) check_state("last");
        if (c == SIL - 10) check_value("hold_valid", note_valid, m_valid);
        if (c == SIL + 20) begin
          model_silence();
          check_state("silence");
        end
      end
    end
    plan.delete();
  endtask

  task automatic full_up(input bit jitter);
    add_note(0, 4, jitter); add_note(1, 4, jitter);
    add_note(2, 4, jitter); add_note(3, 5, jitter);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) nom[k] = int'(spec_nom[k] >> SHIFT);
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // up effect
    add_note(0, 13, 0); add_note(1, 16, 0); add_note(2, 19, 0); add_note(3, 26, 0);
    run_plan(1);
    // down effect
    add_note(4, 10, 0); add_note(5, 8, 0); add_note(6, 7, 0); add_note(7, 6, 0);
    run_plan(1);
    // out of order, then a clean up effect
    add_note(0, 5, 0); add_note(2, 5, 0);
    run_plan(1);
    full_up(0);
    run_plan(1);
    // aborted by silence
    add_note(0, 5, 0); add_note(1, 5, 0);
    run_plan(1);
    // just outside tolerance
    for (int r = 0; r < 20; r++) plan.push_back(int'(170000 >> SHIFT));
    for (int r = 0; r < 20; r++) plan.push_back(nom[0] + TOL + 1);
    run_plan(1);

    // reset during G5
    add_note(0, 4, 0); add_note(1, 4, 0); add_note(2, 5, 0);
    run_plan(0);
    rst = 1'b1; beep_in = 1'b0;
    @(posedge clk); #1;
    check_value("rst_code", note_code, 0);
    check_value("rst_valid", note_valid, 0);
    check_value("rst_period", period_out, 0);
    check_value("rst_up", up_evt, 0);
    check_value("rst_down", down_evt, 0);
    check_value("rst_err", seq_err, 0);
    model_reset();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_state("post_rst");
    full_up(1);
    run_plan(1);

    // randomised scenarios
    for (int s = 0; s < 10; s++) begin
      case ($urandom_range(0, 3))
        0: full_up(1);
        1: for (int k = 4; k < 8; k++) add_note(k, $urandom_range(MIN, MIN + 2), 1);
        2: for (int n = 0; n < 6; n++) begin
             if ($urandom_range(0, 4) == 0) plan.push_back($urandom_range(40, 230));
             else add_note($urandom_range(0, 7), $urandom_range(1, 5), 1);
           end
        default: begin
          int d = $urandom_range(0, 1);
          int len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++) add_note(d ? down_seq[j] : up_seq[j], MIN + 1, 1);
          add_note($urandom_range(0, 7), MIN, 1);
        end
      endcase
      run_plan(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
